// File: rtl/i3c_ccc_pkg.sv
// Shared encodings for the broadcast-CCC sequencer: state codes, tx/rx modes,
// and the default regfile map used when the sequencer is instantiated bare.
package i3c_ccc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BCAST = 3'd1,
    S_ACK   = 3'd2,
    S_CCC   = 3'd3,
    S_CCC_T = 3'd4,
    S_DEF   = 3'd5,
    S_DEF_T = 3'd6
  } state_e;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] TX_SERIAL = 3'b001;
  localparam logic [2:0] TX_TBIT   = 3'b011;
  localparam logic [2:0] RX_ARB    = 3'b010;
  localparam logic [2:0] RX_ACK    = 3'b000;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_BCAST_ADDR = 46;
  localparam int DEF_CCC_BASE   = 50;
  localparam int DEF_DEF_BASE   = 58;

endpackage

// File: rtl/bcast_ccc_seq_if.sv
// Control bundle between the I3C engine and the broadcast-CCC sequencer.
// The engine side (master) issues the request and tx/rx feedback; the
// sequencer (slave) drives the shared tx/rx/bit-counter/regfile controls.
interface bcast_ccc_seq_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 3,
  parameter int DCW    = 3
);

  logic              i_engine_en;
  logic [IDX_W-1:0]  i_ccc_idx;
  logic [DCW-1:0]    i_def_cnt;
  logic              i_tx_mode_done;
  logic              i_rx_ack_nack;

  logic              o_pp_od;
  logic              o_bit_cnt_en;
  logic              o_regf_rd_en;
  logic [ADDR_W-1:0] o_regf_addr;
  logic              o_tx_en;
  logic [2:0]        o_tx_mode;
  logic              o_rx_en;
  logic [2:0]        o_rx_mode;
  logic              o_done;
  logic              o_nack_err;

  modport master (
    output i_engine_en, i_ccc_idx, i_def_cnt, i_tx_mode_done, i_rx_ack_nack,
    input  o_pp_od, o_bit_cnt_en, o_regf_rd_en, o_regf_addr, o_tx_en,
           o_tx_mode, o_rx_en, o_rx_mode, o_done, o_nack_err
  );

  modport slave (
    input  i_engine_en, i_ccc_idx, i_def_cnt, i_tx_mode_done, i_rx_ack_nack,
    output o_pp_od, o_bit_cnt_en, o_regf_rd_en, o_regf_addr, o_tx_en,
           o_tx_mode, o_rx_en, o_rx_mode, o_done, o_nack_err
  );

endinterface

// File: rtl/bcast_ccc_seq.sv
// Broadcast-CCC sequencer: 7E+W, ACK check with NACK retry, CCC byte + T bit,
// then up to MAX_DEF defining bytes each followed by a T bit.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for i_engine_en
//   BCAST   | serialising 7E+W (open-drain, arbitration)
//   ACK     | one-cycle ACK/NACK evaluation
//   CCC     | serialising the selected CCC code (push-pull)
//   CCC_T   | T bit after the CCC code
//   DEF     | serialising defining byte def_ptr
//   DEF_T   | T bit after defining byte def_ptr
//
// All outputs are registered from the next-state decode, so every strobe is
// visible in exactly the first cycle of the state it belongs to.
module bcast_ccc_seq
  import i3c_ccc_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BCAST_ADDR = DEF_BCAST_ADDR,
  parameter int CCC_BASE   = DEF_CCC_BASE,
  parameter int DEF_BASE   = DEF_DEF_BASE,
  parameter int MAX_DEF    = 4,
  parameter int NACK_RETRY = 2,
  parameter int IDX_W      = 3
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  bcast_ccc_seq_if.slave bus
);

  localparam int DCW = $clog2(MAX_DEF + 1);
  // +2 keeps the retry counter at least one bit wide when NACK_RETRY is 0
  localparam int RW  = $clog2(NACK_RETRY + 2);

  localparam logic [DCW-1:0]    MAX_DEF_C = DCW'(MAX_DEF);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(NACK_RETRY);
  localparam logic [ADDR_W-1:0] BCAST_A   = ADDR_W'(BCAST_ADDR);
  localparam logic [ADDR_W-1:0] CCC_A     = ADDR_W'(CCC_BASE);
  localparam logic [ADDR_W-1:0] DEF_A     = ADDR_W'(DEF_BASE);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DCW-1:0]    def_cnt_q, def_cnt_d;
  logic [DCW-1:0]    def_ptr_q, def_ptr_d;
  logic [RW-1:0]     retry_q, retry_d;

  logic              pp_od_q, pp_od_d;
  logic              bit_cnt_en_q, bit_cnt_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tx_en_q, tx_en_d;
  logic [2:0]        tx_mode_q, tx_mode_d;
  logic              rx_en_q, rx_en_d;
  logic [2:0]        rx_mode_q, rx_mode_d;
  logic              done_q, done_d;
  logic              nack_err_q, nack_err_d;

  // Next-state decode and next values of every registered output
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    def_cnt_d  = def_cnt_q;
    def_ptr_d  = def_ptr_q;
    retry_d    = retry_q;
    rd_en_d    = 1'b0;
    addr_d     = '0;
    tx_en_d    = 1'b0;
    tx_mode_d  = MODE_NONE;
    rx_en_d    = 1'b0;
    rx_mode_d  = MODE_NONE;
    done_d     = 1'b0;
    nack_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_engine_en) begin
          idx_d     = bus.i_ccc_idx;
          def_cnt_d = (bus.i_def_cnt > MAX_DEF_C) ? MAX_DEF_C : bus.i_def_cnt;
          def_ptr_d = '0;
          retry_d   = '0;
          state_d   = S_BCAST;
          rd_en_d   = 1'b1;
          addr_d    = BCAST_A;
          tx_en_d   = 1'b1;
          tx_mode_d = TX_SERIAL;
          rx_en_d   = 1'b1;
          rx_mode_d = RX_ARB;
        end
      end
      S_BCAST: begin
        if (bus.i_tx_mode_done) begin
          state_d   = S_ACK;
          rx_en_d   = 1'b1;
          rx_mode_d = RX_ACK;
        end
      end
      S_ACK: begin
        if (!bus.i_rx_ack_nack) begin
          state_d   = S_CCC;
          rd_en_d   = 1'b1;
          addr_d    = CCC_A + ADDR_W'(idx_q);
          tx_en_d   = 1'b1;
          tx_mode_d = TX_SERIAL;
        end else if (retry_q < RETRY_MAX) begin
          // re-issue the broadcast header; the latched request is kept
          retry_d   = retry_q + RW'(1);
          state_d   = S_BCAST;
          rd_en_d   = 1'b1;
          addr_d    = BCAST_A;
          tx_en_d   = 1'b1;
          tx_mode_d = TX_SERIAL;
          rx_en_d   = 1'b1;
          rx_mode_d = RX_ARB;
        end else begin
          state_d    = S_IDLE;
          nack_err_d = 1'b1;
        end
      end
      S_CCC: begin
        if (bus.i_tx_mode_done) begin
          state_d   = S_CCC_T;
          tx_en_d   = 1'b1;
          tx_mode_d = TX_TBIT;
        end
      end
      S_CCC_T: begin
        if (bus.i_tx_mode_done) begin
          if (def_cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_DEF;
            rd_en_d   = 1'b1;
            addr_d    = DEF_A + ADDR_W'(def_ptr_q);
            tx_en_d   = 1'b1;
            tx_mode_d = TX_SERIAL;
          end
        end
      end
      S_DEF: begin
        if (bus.i_tx_mode_done) begin
          state_d   = S_DEF_T;
          tx_en_d   = 1'b1;
          tx_mode_d = TX_TBIT;
        end
      end
      S_DEF_T: begin
        if (bus.i_tx_mode_done) begin
          if ((def_ptr_q + DCW'(1)) == def_cnt_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            def_ptr_d = def_ptr_q + DCW'(1);
            state_d   = S_DEF;
            rd_en_d   = 1'b1;
            addr_d    = DEF_A + ADDR_W'(def_ptr_d);
            tx_en_d   = 1'b1;
            tx_mode_d = TX_SERIAL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides anything decoded above, including a same-cycle tx done
    if (state_q != S_IDLE && !bus.i_engine_en) begin
      state_d    = S_IDLE;
      rd_en_d    = 1'b0;
      addr_d     = '0;
      tx_en_d    = 1'b0;
      tx_mode_d  = MODE_NONE;
      rx_en_d    = 1'b0;
      rx_mode_d  = MODE_NONE;
      done_d     = 1'b0;
      nack_err_d = 1'b0;
    end

    pp_od_d      = (state_d == S_CCC) || (state_d == S_CCC_T) ||
                   (state_d == S_DEF) || (state_d == S_DEF_T);
    bit_cnt_en_d = (state_d != S_IDLE);
  end

  // State, latched request, counters and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      def_cnt_q    <= '0;
      def_ptr_q    <= '0;
      retry_q      <= '0;
      pp_od_q      <= 1'b0;
      bit_cnt_en_q <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      tx_en_q      <= 1'b0;
      tx_mode_q    <= MODE_NONE;
      rx_en_q      <= 1'b0;
      rx_mode_q    <= MODE_NONE;
      done_q       <= 1'b0;
      nack_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      def_cnt_q    <= def_cnt_d;
      def_ptr_q    <= def_ptr_d;
      retry_q      <= retry_d;
      pp_od_q      <= pp_od_d;
      bit_cnt_en_q <= bit_cnt_en_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      tx_en_q      <= tx_en_d;
      tx_mode_q    <= tx_mode_d;
      rx_en_q      <= rx_en_d;
      rx_mode_q    <= rx_mode_d;
      done_q       <= done_d;
      nack_err_q   <= nack_err_d;
    end
  end

  assign bus.o_pp_od      = pp_od_q;
  assign bus.o_bit_cnt_en = bit_cnt_en_q;
  assign bus.o_regf_rd_en = rd_en_q;
  assign bus.o_regf_addr  = addr_q;
  assign bus.o_tx_en      = tx_en_q;
  assign bus.o_tx_mode    = tx_mode_q;
  assign bus.o_rx_en      = rx_en_q;
  assign bus.o_rx_mode    = rx_mode_q;
  assign bus.o_done       = done_q;
  assign bus.o_nack_err   = nack_err_q;

endmodule

// File: tb/tb_bcast_ccc_seq.sv
// Directed bench for bcast_ccc_seq: a reactive engine model answers tx strobes
// with i_tx_mode_done two cycles later and supplies scripted ACK/NACK.
module tb_bcast_ccc_seq;

  logic clk;
  logic rst_n;

  bcast_ccc_seq_if #(.ADDR_W(10), .IDX_W(3), .DCW(3)) bus ();

  bcast_ccc_seq #(
    .ADDR_W(10), .BCAST_ADDR(46), .CCC_BASE(50), .DEF_BASE(58),
    .MAX_DEF(4), .NACK_RETRY(2), .IDX_W(3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int reads[$];
  int n_bcast, n_tbit, n_txdone, n_done, n_nerr, done_lat;
  bit pp_seen0, pp_seen1, pp_bad;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {9'd0, bus.o_pp_od, bus.o_bit_cnt_en, bus.o_regf_rd_en, bus.o_regf_addr,
            bus.o_tx_en, bus.o_tx_mode, bus.o_rx_en, bus.o_rx_mode,
            bus.o_done, bus.o_nack_err};
  endfunction

  function automatic int read_at(input int i);
    return (i < reads.size()) ? reads[i] : -1;
  endfunction

  // mode 0: normal, 1: abort together with the first DEF done, 2: reset on CCC entry
  task automatic run_seq(input int idx, input int dcnt, input int nacks, input int mode);
    int  cnt, nack_seen, last_done_cyc;
    bit  fin, cur_def, in_bcast, aborted;
    reads.delete();
    n_bcast = 0; n_tbit = 0; n_txdone = 0; n_done = 0; n_nerr = 0; done_lat = -1;
    pp_seen0 = 0; pp_seen1 = 0; pp_bad = 0;
    cnt = -1; nack_seen = 0; last_done_cyc = -10;
    fin = 0; cur_def = 0; in_bcast = 0; aborted = 0;
    @(negedge clk);
    bus.i_ccc_idx      = 3'(idx);
    bus.i_def_cnt      = 3'(dcnt);
    bus.i_rx_ack_nack  = 1'b0;
    bus.i_tx_mode_done = 1'b0;
    bus.i_engine_en    = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      bus.i_tx_mode_done = 1'b0;
      if (bus.o_regf_rd_en) begin
        reads.push_back(int'(bus.o_regf_addr));
        if (bus.o_regf_addr == 10'd46) n_bcast++;
      end
      if (bus.o_tx_en && bus.o_tx_mode == 3'b011) n_tbit++;
      if (bus.o_bit_cnt_en) begin
        if (bus.o_pp_od) pp_seen1 = 1;
        else begin
          pp_seen0 = 1;
          if (pp_seen1) pp_bad = 1;
        end
      end
      if (bus.o_done) begin
        n_done++;
        done_lat = cyc - last_done_cyc;
      end
      if (bus.o_nack_err) n_nerr++;
      if (aborted) begin
        check("abort_outputs_zero", out_vec(), 32'd0);
        fin = 1;
      end else if (bus.o_done || bus.o_nack_err) begin
        bus.i_engine_en = 1'b0;
        fin = 1;
      end else if (mode == 2 && bus.o_regf_rd_en && bus.o_regf_addr == 10'(50 + idx)) begin
        #2 rst_n = 1'b0;
        #1 check("reset_mid_ccc_outputs", out_vec(), 32'd0);
        bus.i_engine_en = 1'b0;
        #1 rst_n = 1'b1;
        fin = 1;
      end else begin
        if (bus.o_tx_en) begin
          cnt      = 2;
          cur_def  = bus.o_regf_rd_en && (bus.o_regf_addr >= 10'd58);
          in_bcast = bus.o_rx_en && (bus.o_rx_mode == 3'b010);
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.i_tx_mode_done = 1'b1;
            if (!in_bcast) n_txdone++;
            last_done_cyc = cyc;
            cnt = -1;
            if (mode == 1 && cur_def) begin
              bus.i_engine_en = 1'b0;
              aborted = 1;
            end
          end
        end
        if (bus.o_rx_en && bus.o_rx_mode == 3'b000) begin
          bus.i_rx_ack_nack = (nack_seen < nacks);
          nack_seen++;
        end
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    bus.i_tx_mode_done = 1'b0;
    bus.i_engine_en    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done) n_done++;
      if (bus.o_nack_err) n_nerr++;
    end
  endtask

  initial begin
    bus.i_engine_en    = 1'b0;
    bus.i_ccc_idx      = '0;
    bus.i_def_cnt      = '0;
    bus.i_tx_mode_done = 1'b0;
    bus.i_rx_ack_nack  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: idx 0, no defining bytes
    run_seq(0, 0, 0, 0);
    check("t1_reads", reads.size(), 2);
    check("t1_rd0", read_at(0), 46);
    check("t1_rd1", read_at(1), 50);
    check("t1_tbits", n_tbit, 1);
    check("t1_done", n_done, 1);
    check("t1_done_latency", done_lat, 1);
    check("t1_pp_order", {29'd0, pp_seen0, pp_seen1, pp_bad}, 32'd6);
    check("t1_idle_outputs", out_vec(), 32'd0);

    // 2: idx 3, two defining bytes
    run_seq(3, 2, 0, 0);
    check("t2_reads", reads.size(), 4);
    check("t2_rd0", read_at(0), 46);
    check("t2_rd1", read_at(1), 53);
    check("t2_rd2", read_at(2), 58);
    check("t2_rd3", read_at(3), 59);
    check("t2_tx_done_pulses", n_txdone, 6);
    check("t2_done", n_done, 1);

    // 3: two NACKs then ACK
    run_seq(2, 1, 2, 0);
    check("t3_bcast_entries", n_bcast, 3);
    check("t3_done", n_done, 1);
    check("t3_nack_err", n_nerr, 0);
    check("t3_last_read", read_at(reads.size() - 1), 58);

    // 4: retries exhausted
    run_seq(1, 1, 3, 0);
    check("t4_bcast_entries", n_bcast, 3);
    check("t4_nack_err", n_nerr, 1);
    check("t4_done", n_done, 0);
    check("t4_idle_outputs", out_vec(), 32'd0);

    // 5: abort in DEF on the same cycle as its tx done
    run_seq(1, 2, 0, 1);
    check("t5_reads", reads.size(), 3);
    check("t5_tbits", n_tbit, 1);
    check("t5_done", n_done, 0);

    // 6: defining-byte count clamps to MAX_DEF
    run_seq(0, 7, 0, 0);
    check("t6_reads", reads.size(), 6);
    check("t6_rd2", read_at(2), 58);
    check("t6_rd5", read_at(5), 61);
    check("t6_tbits", n_tbit, 5);
    check("t6_done", n_done, 1);

    // 6b: asynchronous reset on CCC entry
    run_seq(0, 2, 0, 2);
    check("t6b_done", n_done, 0);
    check("t6b_idle_outputs", out_vec(), 32'd0);

    // sequencer still usable after the reset
    run_seq(4, 1, 0, 0);
    check("t7_rd1", read_at(1), 54);
    check("t7_done", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
